// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two core requesters, the arbiter and the SDRAM controller's Avalon-MM slave.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    localparam int BE_W = DATA_W / 8;

    logic [2*ADDR_W-1:0] req_address;
    logic [1:0]          req_read;
    logic [1:0]          req_write;
    logic [2*DATA_W-1:0] req_writedata;
    logic [2*BE_W-1:0]   req_byteenable;
    logic [1:0]          req_waitrequest;
    logic [DATA_W-1:0]   req_readdata;
    logic [1:0]          req_readdatavalid;

    logic [ADDR_W-1:0]   s_address;
    logic                s_read;
    logic                s_write;
    logic [DATA_W-1:0]   s_writedata;
    logic [BE_W-1:0]     s_byteenable;
    logic                s_waitrequest;
    logic [DATA_W-1:0]   s_readdata;
    logic                s_readdatavalid;

    modport master (
        input  req_address, req_read, req_write, req_writedata, req_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output s_address, s_read, s_write, s_writedata, s_byteenable
    );

    modport slave (
        output req_address, req_read, req_write, req_writedata, req_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  s_address, s_read, s_write, s_writedata, s_byteenable
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM slave between two requesters; an in-order
// tag FIFO steers each returning read to the requester that issued it.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4,
    localparam int CNT_W      = $clog2(MAX_PENDING) + 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    sdram_port_arbiter_if.master bus,
    output logic [CNT_W-1:0] pending_count,
    output logic             protocol_error
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_PENDING);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             tag_mem [MAX_PENDING];

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] eligible;
    logic       cmd_read;
    logic       cmd_write;
    logic       accept;
    logic       push;
    logic       pop;

    assign fifo_full  = (pending_count == CNT_W'(MAX_PENDING));
    assign fifo_empty = (pending_count == '0);

    // A requester driving both read and write is treated as a read.
    assign eligible = (bus.req_read & {2{~fifo_full}}) | (bus.req_write & ~bus.req_read);

    assign cmd_read  = (state == GRANT) & bus.req_read[owner] & ~fifo_full;
    assign cmd_write = (state == GRANT) & bus.req_write[owner] & ~bus.req_read[owner];
    assign accept    = (cmd_read | cmd_write) & ~bus.s_waitrequest;
    assign push      = accept & cmd_read;
    assign pop       = bus.s_readdatavalid & ~fifo_empty;

    assign bus.s_read       = cmd_read;
    assign bus.s_write      = cmd_write;
    assign bus.s_address    = owner ? bus.req_address[ADDR_W +: ADDR_W] : bus.req_address[0 +: ADDR_W];
    assign bus.s_writedata  = owner ? bus.req_writedata[DATA_W +: DATA_W] : bus.req_writedata[0 +: DATA_W];
    assign bus.s_byteenable = owner ? bus.req_byteenable[BE_W +: BE_W] : bus.req_byteenable[0 +: BE_W];

    assign bus.req_waitrequest   = ~({1'b0, accept} << owner);
    assign bus.req_readdata      = bus.s_readdata;
    assign bus.req_readdatavalid = {pop & tag_mem[rd_ptr], pop & ~tag_mem[rd_ptr]};

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        owner <= (&eligible) ? ~last_grant : eligible[1];
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if (!(cmd_read || cmd_write)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pending_count  <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
            if (bus.s_readdatavalid && fifo_empty) protocol_error <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset; entries are only read after being written, guarded by the pointers.
    always_ff @(posedge clk_clk) begin
        if (push) tag_mem[wr_ptr] <= owner;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: two Avalon requester agents and a pipelined slave agent drive the arbiter,
// while a transaction-level model (owner/last-grant integers plus a tag queue) predicts every cycle.
module tb_sdram_port_arbiter;
    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int MAX_PENDING = 4;
    localparam int CNT_W       = $clog2(MAX_PENDING) + 1;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        be;
    } cmd_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic             clk_clk = 1'b0;
    logic             reset_reset = 1'b1;
    logic [CNT_W-1:0] pending_count;
    logic             protocol_error;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .bus(bus),
        .pending_count(pending_count),
        .protocol_error(protocol_error)
    );

    always #5 clk_clk = ~clk_clk;

    // Agents
    cmd_t q0[$];
    cmd_t q1[$];
    ret_t retq[$];
    int   cyc = 0;
    int   wait_pct = 0;
    int   stall_budget = 0;
    bit   hold_ret = 0;
    bit   stray = 0;
    int   ret_lat = 1;
    bit   use_fixed = 0;
    logic [DATA_W-1:0] fixed_data = '0;
    int   cmd_len = 0;
    int   last_cmd_len = 0;

    // Reference model: who holds the grant (-1 = nobody), who was served last, tags in flight
    int m_owner = -1;
    int m_last  = 1;
    int m_tags[$];
    bit m_err   = 0;

    int acc_log[$];
    int rdv_log[$];
    logic [DATA_W-1:0] rdata_log[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic cmd_t make_cmd(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data, input logic [1:0] be);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.data = data; c.be = be;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        int r;
        r = $urandom_range(9);
        return make_cmd(r < 6 || r == 9, r >= 6, ADDR_W'($urandom), DATA_W'($urandom), 2'($urandom));
    endfunction

    task automatic cycle();
        int o, sz, lat;
        bit rd, wr, acc, rdv_now, e0, e1;
        logic [1:0] exp_wait, exp_rdv;

        bus.req_read       = 2'b00;
        bus.req_write      = 2'b00;
        bus.req_address    = {ADDR_W'($urandom), ADDR_W'($urandom)};
        bus.req_writedata  = {DATA_W'($urandom), DATA_W'($urandom)};
        bus.req_byteenable = 4'($urandom);
        if (q0.size() > 0) begin
            bus.req_read[0] = q0[0].rd;
            bus.req_write[0] = q0[0].wr;
            bus.req_address[0 +: ADDR_W] = q0[0].addr;
            bus.req_writedata[0 +: DATA_W] = q0[0].data;
            bus.req_byteenable[1:0] = q0[0].be;
        end
        if (q1.size() > 0) begin
            bus.req_read[1] = q1[0].rd;
            bus.req_write[1] = q1[0].wr;
            bus.req_address[ADDR_W +: ADDR_W] = q1[0].addr;
            bus.req_writedata[DATA_W +: DATA_W] = q1[0].data;
            bus.req_byteenable[3:2] = q1[0].be;
        end
        bus.s_waitrequest   = (stall_budget > 0) || ($urandom_range(99) < wait_pct);
        rdv_now             = stray || (!hold_ret && retq.size() > 0 && retq[0].due <= cyc);
        bus.s_readdatavalid = rdv_now;
        bus.s_readdata      = (retq.size() > 0 && !stray) ? retq[0].data : DATA_W'($urandom);

        @(negedge clk_clk);
        if (!reset_reset) begin
            o  = m_owner;
            sz = m_tags.size();
            rd = 0;
            wr = 0;
            if (o >= 0) begin
                rd = bus.req_read[o] && sz < MAX_PENDING;
                wr = bus.req_write[o] && !bus.req_read[o];
            end
            acc = (rd || wr) && !bus.s_waitrequest;
            exp_wait = 2'b11;
            if (acc) exp_wait[o] = 1'b0;
            exp_rdv = 2'b00;
            if (bus.s_readdatavalid && sz > 0) exp_rdv[m_tags[0]] = 1'b1;

            check("s_read", bus.s_read, rd);
            check("s_write", bus.s_write, wr);
            if (rd || wr) check("s_address", bus.s_address, bus.req_address[o*ADDR_W +: ADDR_W]);
            if (wr) begin
                check("s_writedata", bus.s_writedata, bus.req_writedata[o*DATA_W +: DATA_W]);
                check("s_byteenable", bus.s_byteenable, bus.req_byteenable[o*2 +: 2]);
            end
            check("req_waitrequest", bus.req_waitrequest, exp_wait);
            check("req_readdatavalid", bus.req_readdatavalid, exp_rdv);
            if (exp_rdv != 2'b00) check("req_readdata", bus.req_readdata, bus.s_readdata);
            check("pending_count", pending_count, sz);
            check("protocol_error", protocol_error, m_err);

            // Model advance: returns pop first, eligibility sees the count from before this cycle
            if (bus.s_readdatavalid) begin
                if (sz > 0) void'(m_tags.pop_front());
                else m_err = 1;
            end
            if (o >= 0) begin
                if (acc) begin
                    if (rd) m_tags.push_back(o);
                    m_last  = o;
                    m_owner = -1;
                end else if (!(rd || wr)) begin
                    m_owner = -1;
                end
            end else begin
                e0 = bus.req_read[0] ? (sz < MAX_PENDING) : bus.req_write[0];
                e1 = bus.req_read[1] ? (sz < MAX_PENDING) : bus.req_write[1];
                if (e0 && e1) m_owner = 1 - m_last;
                else if (e0) m_owner = 0;
                else if (e1) m_owner = 1;
            end

            // Agents react to what the DUT actually did
            if (q0.size() > 0 && (bus.req_read[0] || bus.req_write[0]) && !bus.req_waitrequest[0]) begin
                acc_log.push_back(0);
                void'(q0.pop_front());
            end
            if (q1.size() > 0 && (bus.req_read[1] || bus.req_write[1]) && !bus.req_waitrequest[1]) begin
                acc_log.push_back(1);
                void'(q1.pop_front());
            end
            if (bus.s_read || bus.s_write) begin
                cmd_len++;
                if (stall_budget > 0) stall_budget--;
            end
            if (bus.req_waitrequest != 2'b11) begin
                last_cmd_len = cmd_len;
                cmd_len = 0;
            end
            if (rdv_now && !stray && retq.size() > 0) void'(retq.pop_front());
            if (bus.s_read && !bus.s_waitrequest) begin
                lat = (ret_lat > 0) ? ret_lat : $urandom_range(6, 1);
                retq.push_back('{due: cyc + lat, data: use_fixed ? fixed_data : DATA_W'($urandom)});
            end
            if (bus.req_readdatavalid != 2'b00) begin
                rdv_log.push_back(int'(bus.req_readdatavalid[1]));
                rdata_log.push_back(bus.req_readdata);
            end
        end else begin
            m_owner = -1;
            m_last  = 1;
            m_tags.delete();
            m_err   = 0;
            q0.delete();
            q1.delete();
            retq.delete();
            cmd_len = 0;
            stall_budget = 0;
        end
        @(posedge clk_clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || retq.size() > 0 || m_tags.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, n < budget, 1'b1);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        rdv_log.delete();
        rdata_log.delete();
    endtask

    task automatic do_reset(input int n);
        reset_reset = 1'b1;
        run(n);
        reset_reset = 1'b0;
    endtask

    initial begin
        bus.req_read = '0; bus.req_write = '0; bus.req_address = '0;
        bus.req_writedata = '0; bus.req_byteenable = '0;
        bus.s_waitrequest = 1'b0; bus.s_readdata = '0; bus.s_readdatavalid = 1'b0;
        @(posedge clk_clk);
        #1;

        // Reset state
        do_reset(2);
        run(1);
        check("rst_pending", pending_count, 0);
        check("rst_waitrequest", bus.req_waitrequest, 2'b11);
        check("rst_rdv", bus.req_readdatavalid, 2'b00);
        check("rst_error", protocol_error, 1'b0);

        // Single m0 read, data returns 3 cycles after acceptance
        ret_lat = 3; use_fixed = 1; fixed_data = 16'hBEEF; wait_pct = 0;
        clear_logs();
        q0.push_back(make_cmd(1, 0, 25'h0000123, '0, 2'b11));
        drain("t1_drain", 20);
        check("t1_rdv_count", rdv_log.size(), 1);
        if (rdv_log.size() > 0) begin
            check("t1_rdv_owner", rdv_log[0], 0);
            check("t1_rdata", rdata_log[0], 16'hBEEF);
        end
        check("t1_pending_end", pending_count, 0);

        // Simultaneous reads right after reset: m0 first, then m1
        use_fixed = 0;
        do_reset(1);
        clear_logs();
        q0.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        q1.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        drain("t2_drain", 30);
        check("t2_issued", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t2_first", acc_log[0], 0);
            check("t2_second", acc_log[1], 1);
        end
        q0.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        q1.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        drain("t2b_drain", 30);

        // m1 write stalled by the slave for 5 cycles
        clear_logs();
        stall_budget = 5;
        q1.push_back(make_cmd(0, 1, ADDR_W'($urandom), 16'hA5A5, 2'b11));
        drain("t3_drain", 30);
        check("t3_hold_len", last_cmd_len, 6);
        check("t3_issued", acc_log.size(), 1);

        // Fill the tag FIFO, then a write still passes while a fifth read is held
        clear_logs();
        hold_ret = 1; ret_lat = 1;
        repeat (2) begin
            q0.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
            q1.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        end
        run(14);
        check("t4_pending_full", pending_count, MAX_PENDING);
        check("t4_issued", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            check("t4_order0", acc_log[0], 0);
            check("t4_order1", acc_log[1], 1);
            check("t4_order2", acc_log[2], 0);
            check("t4_order3", acc_log[3], 1);
        end
        q0.push_back(make_cmd(0, 1, ADDR_W'($urandom), DATA_W'($urandom), 2'b01));
        q1.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        run(10);
        check("t5_write_issued", q0.size(), 0);
        check("t5_read_held", q1.size(), 1);
        check("t5_pending", pending_count, MAX_PENDING);
        hold_ret = 0;
        drain("t4_drain", 60);
        check("t4_returns", rdv_log.size(), 5);
        if (rdv_log.size() == 5) begin
            check("t4_ret0", rdv_log[0], 0);
            check("t4_ret1", rdv_log[1], 1);
            check("t4_ret2", rdv_log[2], 0);
            check("t4_ret3", rdv_log[3], 1);
            check("t4_ret4", rdv_log[4], 1);
        end

        // Randomised traffic against the model
        wait_pct = 30; ret_lat = 0;
        for (int i = 0; i < 500; i++) begin
            if (q0.size() == 0 && $urandom_range(99) < 40) q0.push_back(rand_cmd());
            if (q1.size() == 0 && $urandom_range(99) < 40) q1.push_back(rand_cmd());
            cycle();
        end
        wait_pct = 0;
        drain("rand_drain", 200);

        // Reset with reads outstanding, then a stray return
        hold_ret = 1; ret_lat = 1;
        q0.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        q1.push_back(make_cmd(1, 0, ADDR_W'($urandom), '0, 2'b11));
        run(8);
        check("t6_pending_before", pending_count, 2);
        do_reset(1);
        hold_ret = 0;
        run(1);
        check("t6_error_clear", protocol_error, 1'b0);
        stray = 1;
        run(1);
        stray = 0;
        check("t6_error_set", protocol_error, 1'b1);
        run(3);
        check("t6_error_sticky", protocol_error, 1'b1);
        check("t6_pending_after", pending_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
